adder_issue: RTL and testbench

- Issue/collect stage directly upstream of the multi-cycle adder unit (adder3) in the microcoded datapath.
- Accepts one add/sub/compare request per valid/ready handshake and latches its operands.
- Holds the operands stable while the adder iterates, then captures the adder's result into a one-entry response buffer for writeback/branch logic.
- Handles backpressure and pipeline flush without corrupting the adder's internal sequencing.

---
 rtl/adder_issue_if.sv | 65 ++++++
 rtl/adder_issue.sv | 185 ++++++++++++++++++
 tb/tb_adder_issue.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_issue_if.sv
// -----------------------------------------------------------------------------
// adder_issue_pkg / adder_issue_if
//
// Purpose:
//   adder_issue_pkg : operation encoding shared by the issue stage and the
//                     multi-cycle adder (adder3).
//   adder_issue_if  : request/response bundle between the microcode sequencer
//                     (master) and the adder issue stage (slave).
//
// Interface signals:
//   req_valid  / req_ready   request handshake (transfer when both are high)
//   req_op, req_a, req_b     operation and operands
//   req_tag                  opaque tag (destination register index)
//   resp_valid / resp_ready  response handshake
//   resp_data                captured adder result
//   resp_cond                compare outcome (0 for ADD/SUB)
//   resp_tag                 tag of the response
// -----------------------------------------------------------------------------
package adder_issue_pkg;

  typedef enum logic [2:0] {
    ADDER_ADD,
    ADDER_SUB,
    ADDER_EQ,
    ADDER_NE,
    ADDER_LT,
    ADDER_GE,
    ADDER_LTU,
    ADDER_GEU
  } adder_op_t;

endpackage

interface adder_issue_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  import adder_issue_pkg::*;

  logic             req_valid;
  logic             req_ready;
  adder_op_t        req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAGW-1:0]  req_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_cond;
  logic [TAGW-1:0]  resp_tag;

  // Sequencer side: issues requests, consumes responses.
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_cond, resp_tag
  );

  // Issue-stage side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_cond, resp_tag
  );

endinterface

// File: rtl/adder_issue.sv
// -----------------------------------------------------------------------------
// adder_issue
//
// Purpose:
//   Issue/collect stage in front of the multi-cycle adder. Accepts one request,
//   holds its operands on the adder inputs while the adder iterates, captures
//   the result into a one-entry response buffer, and survives flush without
//   desynchronising the adder's internal cycle counter.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (shared with the adder)
//   flush        discard any in-flight or buffered operation
//   bus          adder_issue_if.slave : request / response handshakes
//   adder_start  one-cycle start pulse to the adder
//   adder_op     latched operation
//   adder_src_a  latched operand A (stable from start through done)
//   adder_src_b  latched operand B (stable from start through done)
//   adder_out    adder result; compares return {0..0, cond}
//   adder_done   adder completion (combinational in the adder)
//
// Configuration:
//   ADDER_ISSUE_PIPE_EN  when defined, a request may be accepted in the same
//                        cycle the buffered response is consumed, giving one
//                        op per NCYC+1 cycles instead of NCYC+2.
// -----------------------------------------------------------------------------
module adder_issue
  import adder_issue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  adder_issue_if.slave     bus,
  output logic             adder_start,
  output adder_op_t        adder_op,
  output logic [WIDTH-1:0] adder_src_a,
  output logic [WIDTH-1:0] adder_src_b,
  input  logic [WIDTH-1:0] adder_out,
  input  logic             adder_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t           state_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             adder_start_q;
  logic             resp_cond_q;
  logic [WIDTH-1:0] resp_data_q;
  adder_op_t        op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [TAGW-1:0]  tag_q;

  logic resp_hs;
  logic accept;
  logic is_cmp;

  // Response consumed this cycle; flush takes priority over the consumer.
  assign resp_hs = resp_valid_q && bus.resp_ready && !flush;

  // Ready is gated by flush so that valid && ready is always a real transfer.
`ifdef ADDER_ISSUE_PIPE_EN
  assign bus.req_ready = !flush && (req_ready_q || resp_hs);
`else
  assign bus.req_ready = !flush && req_ready_q;
`endif

  assign accept = bus.req_valid && bus.req_ready;
  assign is_cmp = (op_q != ADDER_ADD) && (op_q != ADDER_SUB);

  // Operand/tag latch: changes only on acceptance so the adder inputs stay
  // stable for the whole iteration, including a drain after flush.
  // NOTE: reset is sampled inside the clocked block (synchronous), and every
  // state register uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= ADDER_ADD;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else if (accept) begin
      op_q  <= bus.req_op;
      a_q   <= bus.req_a;
      b_q   <= bus.req_b;
      tag_q <= bus.req_tag;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      adder_start_q <= 1'b0;
      resp_data_q   <= '0;
      resp_cond_q   <= 1'b0;
    end else begin
      // NOTE: default-low here makes adder_start a single-cycle pulse without
      // having to clear it explicitly in every branch.
      adder_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q       <= S_START;
            adder_start_q <= 1'b1;
            req_ready_q   <= 1'b0;
          end
        end

        // adder_done is a completion only while an operation is in flight.
        S_START, S_WAIT: begin
          if (flush) begin
            if (adder_done) begin
              state_q     <= S_IDLE;
              req_ready_q <= 1'b1;
            end else begin
              // Adder still counting: let it finish so its sequencing stays
              // aligned with ours.
              state_q <= S_DRAIN;
            end
          end else if (adder_done) begin
            resp_data_q  <= adder_out;
            resp_cond_q  <= is_cmp && adder_out[0];
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_RESP: begin
          if (flush || resp_hs) begin
            resp_valid_q <= 1'b0;
            if (accept) begin
              // Only reachable with the pipelined handshake enabled.
              state_q       <= S_START;
              adder_start_q <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end

        // Result of a flushed operation is discarded.
        S_DRAIN: begin
          if (adder_done) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign adder_start    = adder_start_q;
  assign adder_op       = op_q;
  assign adder_src_a    = a_q;
  assign adder_src_b    = b_q;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_cond  = resp_cond_q;
  // Tag register only reloads on acceptance, which never overlaps a pending
  // response, so it doubles as the response tag.
  assign bus.resp_tag   = tag_q;

endmodule

// File: tb/tb_adder_issue.sv
// -----------------------------------------------------------------------------
// tb_adder_issue
//
// Self-checking bench for adder_issue. Contains a cycle-count adder model
// (start -> done after ncyc cycles, done trivially high when idle) and a
// timestamp-based reference model of the issue stage that a single negedge
// compare process checks against every cycle. Directed vectors add literal
// expectations for results, latency, backpressure, flush and reset.
// -----------------------------------------------------------------------------
module tb_adder_issue;
  import adder_issue_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAGW  = 5;
`ifdef ADDER_ISSUE_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  localparam int GAP = PIPE ? 3 : 4;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             flush = 1'b0;
  logic             adder_start;
  logic             adder_done;
  adder_op_t        adder_op;
  logic [WIDTH-1:0] adder_src_a;
  logic [WIDTH-1:0] adder_src_b;
  logic [WIDTH-1:0] adder_out;

  adder_issue_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  adder_issue #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .adder_start (adder_start),
    .adder_op    (adder_op),
    .adder_src_a (adder_src_a),
    .adder_src_b (adder_src_b),
    .adder_out   (adder_out),
    .adder_done  (adder_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] op_result(input adder_op_t op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      ADDER_ADD: r = a + b;
      ADDER_SUB: r = a - b;
      ADDER_EQ:  r[0] = (a == b);
      ADDER_NE:  r[0] = (a != b);
      ADDER_LT:  r[0] = ($signed(a) < $signed(b));
      ADDER_GE:  r[0] = ($signed(a) >= $signed(b));
      ADDER_LTU: r[0] = (a < b);
      ADDER_GEU: r[0] = (a >= b);
      default:   r = '0;
    endcase
    return r;
  endfunction

  // ---------------- adder model ----------------
  int ncyc = 2;
  int acnt = 0;

  always @(posedge clk) begin
    if (rst)              acnt <= 0;
    else if (adder_start) acnt <= ncyc - 1;
    else if (acnt > 0)    acnt <= acnt - 1;
  end

  always_comb begin
    adder_done = adder_start ? (ncyc == 1) : (acnt <= 1);
    // Garbage outside a real completion exposes captures on the wrong cycle.
    adder_out  = (adder_done && (adder_start || acnt != 0))
                 ? op_result(adder_op, adder_src_a, adder_src_b) : 32'hDEAD_BEEF;
  end

  // ---------------- reference model + compare ----------------
  bit               pend = 1'b0;
  int               acc_c = 0, done_at = 0, valid_from = 0, idle_at = 0;
  adder_op_t        e_op;
  logic [WIDTH-1:0] e_a, e_b, e_data;
  logic             e_cond;
  logic [TAGW-1:0]  e_tag;
  bit               ev, er, es;

  int               n_start = 0, resp_cnt = 0, last_lat = 0, fv_c = 0, prev_fv_c = 0;
  logic [WIDTH-1:0] last_data = '0, prev_data = '0;
  logic             last_cond = 1'b0;
  logic [TAGW-1:0]  last_tag = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend    = 1'b0;
      idle_at = cyc + 1;
    end else begin
      ev = pend && (cyc >= valid_from);
      er = !flush && ((!pend && cyc >= idle_at) || (PIPE && ev && bus.resp_ready));
      es = pend && (cyc == acc_c + 1);
      check("resp_valid", bus.resp_valid, ev);
      check("req_ready", bus.req_ready, er);
      check("adder_start", adder_start, es);
      if (adder_start) n_start++;
      if (pend && cyc <= done_at) begin
        check("adder_src_a", adder_src_a, e_a);
        check("adder_src_b", adder_src_b, e_b);
        check("adder_op", adder_op, e_op);
      end
      if (ev) begin
        check("resp_data", bus.resp_data, e_data);
        check("resp_cond", bus.resp_cond, e_cond);
        check("resp_tag", bus.resp_tag, e_tag);
        if (cyc == valid_from) begin
          prev_fv_c = fv_c;
          fv_c      = cyc;
          last_lat  = cyc - acc_c;
        end
      end
      if (pend && flush) begin
        idle_at = (cyc >= done_at) ? cyc + 1 : done_at + 1;
        pend    = 1'b0;
      end else if (ev && bus.resp_ready) begin
        prev_data = last_data;
        last_data = bus.resp_data;
        last_cond = bus.resp_cond;
        last_tag  = bus.resp_tag;
        resp_cnt++;
        pend    = 1'b0;
        idle_at = cyc + 1;
      end
      if (bus.req_valid && er) begin
        pend       = 1'b1;
        acc_c      = cyc;
        done_at    = cyc + ncyc;
        valid_from = cyc + ncyc + 1;
        idle_at    = 32'h7FFF_FFFF;
        e_op       = bus.req_op;
        e_a        = bus.req_a;
        e_b        = bus.req_b;
        e_tag      = bus.req_tag;
        e_data     = op_result(bus.req_op, bus.req_a, bus.req_b);
        e_cond     = (bus.req_op != ADDER_ADD) && (bus.req_op != ADDER_SUB) && e_data[0];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input adder_op_t op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
    bit acc;
    acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = bus.req_ready;
      sync();
    end
    bus.req_valid = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  task automatic wait_resp();
    int c0;
    int n;
    c0 = resp_cnt;
    n  = 0;
    while (resp_cnt == c0 && n < 40) begin
      sync();
      n++;
    end
    check("resp_timeout", resp_cnt != c0, 1);
  endtask

  typedef struct packed {
    adder_op_t        op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             c;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int ns0;
    int c0;
    int n;

    vecs[0] = '{ADDER_ADD, 32'h0000_FFFF, 32'h1,         32'h0001_0000, 1'b0};
    vecs[1] = '{ADDER_SUB, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0};
    vecs[2] = '{ADDER_LT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b1};
    vecs[3] = '{ADDER_LTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0};
    vecs[4] = '{ADDER_GE,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         1'b0};
    vecs[5] = '{ADDER_GEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b1};
    vecs[6] = '{ADDER_EQ,  32'h9,         32'h9,         32'h1,         1'b1};
    vecs[7] = '{ADDER_NE,  32'h9,         32'h9,         32'h0,         1'b0};

    bus.req_valid  = 1'b0;
    bus.req_op     = ADDER_ADD;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_src_a", adder_src_a, 0);
    check("rst_req_ready", bus.req_ready, 1);
    sync();

    // Operation table, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      ns0 = n_start;
      send(vecs[i].op, vecs[i].a, vecs[i].b, TAGW'(i + 3));
      wait_resp();
      check($sformatf("vec%0d_data", i), last_data, vecs[i].d);
      check($sformatf("vec%0d_cond", i), last_cond, vecs[i].c);
      check($sformatf("vec%0d_tag", i), last_tag, i + 3);
      check($sformatf("vec%0d_latency", i), last_lat, 3);
      check($sformatf("vec%0d_start_pulses", i), n_start - ns0, 1);
    end

    // Backpressure: response held for 4 cycles.
    bus.resp_ready = 1'b0;
    send(ADDER_ADD, 32'd2, 32'd2, 5'd7);
    for (int i = 0; i < 20 && !bus.resp_valid; i++) sync();
    check("bp_seen", bus.resp_valid, 1);
    repeat (4) begin
      @(negedge clk);
      check("bp_valid", bus.resp_valid, 1);
      check("bp_data", bus.resp_data, 4);
      check("bp_req_ready", bus.req_ready, 0);
    end
    sync();
    bus.resp_ready = 1'b1;
    wait_resp();
    check("bp_last_data", last_data, 4);
    @(negedge clk);
    check("bp_idle_ready", bus.req_ready, 1);
    sync();

    // Flush in WAIT with a 4-cycle adder: drain until done, no response.
    ncyc = 4;
    c0 = resp_cnt;
    send(ADDER_EQ, 32'd9, 32'd9, 5'd1);
    sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
    end
    check("drain_cycles", n, 2);
    check("flush_wait_no_resp", resp_cnt, c0);
    sync();

    // Flush in START while a 1-cycle adder reports done: straight to idle.
    ncyc = 1;
    send(ADDER_ADD, 32'd5, 32'd5, 5'd2);
    flush = 1'b1;
    sync();
    flush = 1'b0;
    @(negedge clk);
    check("flush_start_ready", bus.req_ready, 1);
    check("flush_start_no_resp", resp_cnt, c0);
    sync();

    // Flush in RESP.
    ncyc = 2;
    bus.resp_ready = 1'b0;
    send(ADDER_ADD, 32'd3, 32'd3, 5'd4);
    for (int i = 0; i < 20 && !bus.resp_valid; i++) sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("flush_resp_valid", bus.resp_valid, 0);
    check("flush_resp_ready", bus.req_ready, 1);
    check("flush_resp_no_resp", resp_cnt, c0);
    sync();

    // Flush and request together in IDLE: flush wins.
    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = ADDER_ADD;
    bus.req_a     = 32'd8;
    bus.req_b     = 32'd8;
    @(negedge clk);
    check("flush_idle_ready", bus.req_ready, 0);
    sync();
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_no_start", adder_start, 0);
    sync();

    // Normal operation after flushes.
    send(ADDER_ADD, 32'd1, 32'd1, 5'd9);
    wait_resp();
    check("post_flush_data", last_data, 2);
    check("post_flush_latency", last_lat, 3);

    // Reset during WAIT.
    ncyc = 4;
    c0 = resp_cnt;
    send(ADDER_ADD, 32'd6, 32'd6, 5'd3);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_resp_valid", bus.resp_valid, 0);
    check("rst_wait_req_ready", bus.req_ready, 1);
    check("rst_wait_start", adder_start, 0);
    check("rst_wait_no_resp", resp_cnt, c0);
    sync();
    ncyc = 2;
    send(ADDER_ADD, 32'd10, 32'd20, 5'd11);
    wait_resp();
    check("post_rst_data", last_data, 30);
    check("post_rst_latency", last_lat, 3);

    // Back-to-back requests.
    c0 = resp_cnt;
    send(ADDER_ADD, 32'd1, 32'd2, 5'd5);
    send(ADDER_SUB, 32'd9, 32'd4, 5'd6);
    n = 0;
    while (resp_cnt < c0 + 2 && n < 40) begin
      sync();
      n++;
    end
    check("b2b_count", resp_cnt - c0, 2);
    check("b2b_first", prev_data, 3);
    check("b2b_second", last_data, 5);
    check("b2b_gap", fv_c - prev_fv_c, GAP);

    sync();
    sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
